// File: rtl/terminal_controller.sv
// -----------------------------------------------------------------------------
// terminal_controller
//
// Memory-mapped front end for the simulation terminal. The CPU pushes characters
// into a TX FIFO through a four-register window. A small FSM drains the FIFO into
// the terminal, one byte per single-cycle term_write pulse. Every byte is followed
// by CHAR_GAP forced idle cycles.
//
// Register window (address):
//   0 DATA     write: push write_data[7:0]; dropped and overflow set when full
//              read : 0
//   1 STATUS   read : bit0 empty, bit1 full, bit2 busy, bit3 overflow,
//                     bit4 enable, bits[15:8] count
//   2 CONTROL  write: bit0 flush + term_reset pulse, bit1 enable value,
//                     bit2 clear overflow
//              read : {30'b0, enable, 1'b0}
//   3 reserved writes ignored, reads 0
//
// Ports:
//   clock         in   system clock, all state changes on posedge
//   reset         in   asynchronous active-low reset
//   write_enable  in   bus write strobe (one transfer per cycle)
//   read_enable   in   bus read strobe
//   address       in   [1:0] register select
//   write_data    in   [31:0] bus write data
//   read_data     out  [31:0] registered read data, valid the cycle after read_enable
//   term_write    out  terminal write pulse, one cycle per byte
//   term_data     out  [7:0] terminal data, valid while term_write = 1
//   term_reset    out  terminal reset pulse, never coincident with term_write
//   irq_empty     out  enabled, FIFO empty and FSM idle
//   dbg_state     out  [1:0] FSM state (0 IDLE, 1 SEND, 2 GAP)
//
// Bus handshake: the bus has no valid/ready pair. A strobe is accepted in the
// cycle it is high, with no backpressure. A DATA write to a full FIFO is
// therefore not stalled. It is dropped and recorded in the sticky overflow flag.
// When write_enable and read_enable are both high, both take effect. The read
// sees the state as it was before the write.
// -----------------------------------------------------------------------------
module terminal_controller #(
  parameter int FIFO_DEPTH = 16,
  parameter int CHAR_GAP   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic [1:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        term_write,
  output logic [7:0]  term_data,
  output logic        term_reset,
  output logic        irq_empty,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (CHAR_GAP > 1) ? $clog2(CHAR_GAP) : 1;
  localparam int GAP_LOAD_I = (CHAR_GAP > 0) ? CHAR_GAP - 1 : 0;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_LOAD_I);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      byte_q, byte_d;
  logic            overflow_q, overflow_d;
  logic            enable_q, enable_d;
  logic            term_reset_q, term_reset_d;
  logic            rst_pend_q, rst_pend_d;
  logic            irq_q, irq_d;
  logic [31:0]     read_data_q, read_data_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic            wr_data, wr_ctrl, flush, push, pop, full, empty;
  logic [31:0]     status;
  logic            unused_wdata;

  assign unused_wdata = ^write_data[31:8];

  assign wr_data = write_enable && (address == 2'd0);
  assign wr_ctrl = write_enable && (address == 2'd2);
  assign flush   = wr_ctrl && write_data[0];
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  // Fullness is judged on the count at the start of the cycle, so a push while
  // full is dropped even if the FSM pops in the same cycle. A flush also
  // discards any push in the same cycle.
  assign push    = wr_data && !full && !flush;

  // FSM next state. The pop happens on the IDLE->SEND transition edge, and the
  // popped byte is held in byte_q for the single SEND cycle.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable_q && !empty) begin
          state_d = S_SEND;
          pop     = 1'b1;
        end
      end
      S_SEND: begin
        if (CHAR_GAP > 0) begin
          state_d = S_GAP;
          gap_d   = GAP_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    status        = 32'd0;
    status[0]     = empty;
    status[1]     = full;
    status[2]     = (state_q != S_IDLE);
    status[3]     = overflow_q;
    status[4]     = enable_q;
    status[15:8]  = 8'(count_q);
  end

  // FIFO pointers, flags and output registers.
  always_comb begin
    wr_ptr_d     = wr_ptr_q + AW'(push);
    rd_ptr_d     = rd_ptr_q + AW'(pop);
    count_d      = count_q + CW'(push) - CW'(pop);
    byte_d       = pop ? mem_q[rd_ptr_q] : byte_q;
    overflow_d   = overflow_q;
    enable_d     = enable_q;
    term_reset_d = 1'b0;
    rst_pend_d   = 1'b0;
    read_data_d  = read_data_q;

    // A flush empties the FIFO. A byte popped on the same edge is already in
    // flight and is still sent.
    if (flush) begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end

    if (wr_data && full) overflow_d = 1'b1;
    if (wr_ctrl) begin
      enable_d = write_data[1];
      if (write_data[2]) overflow_d = 1'b0;
    end

    // A term_reset request waits while the next cycle carries a term_write.
    if (flush || rst_pend_q) begin
      if (state_d == S_SEND) rst_pend_d   = 1'b1;
      else                   term_reset_d = 1'b1;
    end

    if (read_enable) begin
      case (address)
        2'd1:    read_data_d = status;
        2'd2:    read_data_d = {30'd0, enable_q, 1'b0};
        default: read_data_d = 32'd0;
      endcase
    end
  end

  // irq is registered from next-state values. It stays low under reset and
  // tracks the FIFO and FSM state without a cycle of lag.
  assign irq_d = enable_d && (count_d == '0) && (state_d == S_IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      gap_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      byte_q       <= 8'd0;
      overflow_q   <= 1'b0;
      enable_q     <= 1'b1;
      term_reset_q <= 1'b0;
      rst_pend_q   <= 1'b0;
      irq_q        <= 1'b0;
      read_data_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      byte_q       <= byte_d;
      overflow_q   <= overflow_d;
      enable_q     <= enable_d;
      term_reset_q <= term_reset_d;
      rst_pend_q   <= rst_pend_d;
      irq_q        <= irq_d;
      read_data_q  <= read_data_d;
    end
  end

  // FIFO storage has no reset. Entries are only read after being written.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= write_data[7:0];
  end

  assign read_data  = read_data_q;
  assign term_write = (state_q == S_SEND);
  assign term_data  = byte_q;
  assign term_reset = term_reset_q;
  assign irq_empty  = irq_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_terminal_controller.sv
module tb_terminal_controller;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Instance a: default build (CHAR_GAP = 4). Instance b: CHAR_GAP = 0.
  logic        we_a = 0, re_a = 0, we_b = 0, re_b = 0;
  logic [1:0]  addr_a = 0, addr_b = 0;
  logic [31:0] wd_a = 0, wd_b = 0;
  logic [31:0] rd_a, rd_b;
  logic        tw_a, tw_b, tr_a, tr_b, irq_a, irq_b;
  logic [7:0]  td_a, td_b;
  logic [1:0]  st_a, st_b;

  terminal_controller #(.FIFO_DEPTH(16), .CHAR_GAP(4)) dut_a (
    .clock(clock), .reset(rst_n), .write_enable(we_a), .read_enable(re_a),
    .address(addr_a), .write_data(wd_a), .read_data(rd_a), .term_write(tw_a),
    .term_data(td_a), .term_reset(tr_a), .irq_empty(irq_a), .dbg_state(st_a)
  );

  terminal_controller #(.FIFO_DEPTH(16), .CHAR_GAP(0)) dut_b (
    .clock(clock), .reset(rst_n), .write_enable(we_b), .read_enable(re_b),
    .address(addr_b), .write_data(wd_b), .read_data(rd_b), .term_write(tw_b),
    .term_data(td_b), .term_reset(tr_b), .irq_empty(irq_b), .dbg_state(st_b)
  );

  // ---------------- scoreboard ----------------
  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  pulse_a[$];
  int          pcyc_a[$];
  int          trcyc_a[$];
  logic [7:0]  pulse_b[$];
  int          pcyc_b[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Terminal-side monitors sample on negedge, as the terminal does.
  always @(negedge clock) begin
    if (tw_a === 1'b1) begin
      pulse_a.push_back(td_a);
      pcyc_a.push_back(cyc);
    end
    if (tr_a === 1'b1) begin
      trcyc_a.push_back(cyc);
      check("treset_excl_twrite", {31'd0, tw_a}, 32'd0);
    end
    if (tw_b === 1'b1) begin
      pulse_b.push_back(td_b);
      pcyc_b.push_back(cyc);
      check("irq_b_low_in_send", {31'd0, irq_b}, 32'd0);
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic sel, input logic we, input logic re,
                       input logic [1:0] a, input logic [31:0] d);
    if (sel) begin
      we_b = we; re_b = re; addr_b = a; wd_b = d;
    end else begin
      we_a = we; re_a = re; addr_a = a; wd_a = d;
    end
  endtask

  task automatic bus_write(input logic sel, input logic [1:0] a, input logic [31:0] d);
    drive(sel, 1'b1, 1'b0, a, d);
    tick();
    drive(sel, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic bus_read(input logic sel, input logic [1:0] a, output logic [31:0] d);
    drive(sel, 1'b0, 1'b1, a, 32'd0);
    tick();
    drive(sel, 1'b0, 1'b0, 2'd0, 32'd0);
    d = sel ? rd_b : rd_a;
  endtask

  task automatic bus_wr_rd(input logic [1:0] a, input logic [31:0] d, output logic [31:0] r);
    drive(1'b0, 1'b1, 1'b1, a, d);
    tick();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    r = rd_a;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_pulses(input logic sel, input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (((sel ? pulse_b.size() : pulse_a.size()) < n) && (k < budget)) begin
      tick();
      k++;
    end
    check(tag, sel ? pulse_b.size() : pulse_a.size(), n);
  endtask

  task automatic clear_mon();
    pulse_a.delete(); pcyc_a.delete(); trcyc_a.delete();
    pulse_b.delete(); pcyc_b.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] r;
    int c0;
    logic [7:0] e;

    // Reset values while reset is held low.
    ticks(2);
    check("rst_read_data", rd_a, 32'd0);
    check("rst_term_write", {31'd0, tw_a}, 32'd0);
    check("rst_term_data", {24'd0, td_a}, 32'd0);
    check("rst_term_reset", {31'd0, tr_a}, 32'd0);
    check("rst_irq", {31'd0, irq_a}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("irq_after_rst", {31'd0, irq_a}, 32'd1);
    check("state_after_rst", {30'd0, st_a}, 32'd0);

    // 1) two bytes, latency 2, spacing CHAR_GAP+2 = 6.
    clear_mon();
    c0 = cyc;
    bus_write(0, 2'd0, 32'h41);
    bus_write(0, 2'd0, 32'h42);
    wait_pulses(0, 2, 30, "t1_pulses");
    if (pulse_a.size() == 2) begin
      check("t1_byte0", {24'd0, pulse_a[0]}, 32'h41);
      check("t1_byte1", {24'd0, pulse_a[1]}, 32'h42);
      check("t1_latency", pcyc_a[0] - c0, 32'd2);
      check("t1_spacing", pcyc_a[1] - pcyc_a[0], 32'd6);
    end
    ticks(8);
    bus_read(0, 2'd1, r);
    check("t1_status", r, 32'h0011);
    check("t1_irq", {31'd0, irq_a}, 32'd1);

    // 2) overflow with enable cleared, then drain 16 bytes in order.
    bus_write(0, 2'd2, 32'h0);
    for (int i = 0; i < 17; i++) bus_write(0, 2'd0, 32'h50 + i);
    bus_read(0, 2'd1, r);
    check("t2_status_full", r, 32'h100A);
    clear_mon();
    bus_write(0, 2'd2, 32'h2);
    bus_read(0, 2'd1, r);
    check("t2_status_enabled", r, 32'h101A);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h50 + 8'(i));
    wait_pulses(0, 16, 130, "t2_pulses");
    while (exp_q.size() > 0 && pulse_a.size() > 0) begin
      e = exp_q.pop_front();
      check("t2_byte", {24'd0, pulse_a.pop_front()}, {24'd0, e});
    end
    exp_q.delete();
    if (pcyc_a.size() == 16) check("t2_span", pcyc_a[15] - pcyc_a[0], 32'd90);
    ticks(8);
    bus_read(0, 2'd1, r);
    check("t2_status_ovf", r, 32'h0019);
    bus_write(0, 2'd2, 32'h6);
    bus_read(0, 2'd1, r);
    check("t2_status_clr", r, 32'h0011);

    // 3) flush while SEND with 5 bytes queued.
    bus_write(0, 2'd2, 32'h0);
    for (int i = 0; i < 6; i++) bus_write(0, 2'd0, 32'h70 + i);
    clear_mon();
    bus_write(0, 2'd2, 32'h2);
    tick();
    check("t3_in_send", {30'd0, st_a}, 32'd1);
    bus_write(0, 2'd2, 32'h3);
    check("t3_treset", {31'd0, tr_a}, 32'd1);
    ticks(20);
    check("t3_npulses", pulse_a.size(), 32'd1);
    if (pulse_a.size() >= 1) check("t3_byte", {24'd0, pulse_a[0]}, 32'h70);
    check("t3_ntreset", trcyc_a.size(), 32'd1);
    bus_read(0, 2'd1, r);
    check("t3_status", r, 32'h0011);

    // 3b) flush on the same edge as a pop: term_reset waits one cycle.
    clear_mon();
    c0 = cyc;
    bus_write(0, 2'd0, 32'h80);
    bus_write(0, 2'd0, 32'h81);
    bus_write(0, 2'd0, 32'h82);
    ticks(4);
    bus_write(0, 2'd2, 32'h3);
    check("t3b_tw_high", {31'd0, tw_a}, 32'd1);
    check("t3b_tr_low", {31'd0, tr_a}, 32'd0);
    tick();
    check("t3b_tr_high", {31'd0, tr_a}, 32'd1);
    check("t3b_tw_low", {31'd0, tw_a}, 32'd0);
    ticks(12);
    check("t3b_npulses", pulse_a.size(), 32'd2);
    if (pulse_a.size() == 2) check("t3b_byte1", {24'd0, pulse_a[1]}, 32'h81);
    check("t3b_ntreset", trcyc_a.size(), 32'd1);
    if (trcyc_a.size() == 1) check("t3b_tr_cycle", trcyc_a[0] - c0, 32'd9);

    // 4) CHAR_GAP = 0 build: pulses every 2 cycles, irq after last byte.
    bus_write(1, 2'd2, 32'h0);
    for (int i = 0; i < 4; i++) bus_write(1, 2'd0, 32'hA0 + i);
    clear_mon();
    bus_write(1, 2'd2, 32'h2);
    wait_pulses(1, 4, 30, "t4_pulses");
    check("t4_irq_after", {31'd0, irq_b}, 32'd1);
    if (pulse_b.size() == 4) begin
      for (int i = 0; i < 4; i++) check("t4_byte", {24'd0, pulse_b[i]}, 32'hA0 + i);
      for (int i = 1; i < 4; i++) check("t4_spacing", pcyc_b[i] - pcyc_b[i-1], 32'd2);
    end

    // 5) reset asserted in the middle of a SEND cycle.
    bus_read(0, 2'd1, r);
    bus_write(0, 2'd0, 32'h90);
    bus_write(0, 2'd0, 32'h91);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (tw_a === 1'b1) break;
    end
    check("t5_pre_send", {31'd0, tw_a}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_tw", {31'd0, tw_a}, 32'd0);
    check("t5_td", {24'd0, td_a}, 32'd0);
    check("t5_tr", {31'd0, tr_a}, 32'd0);
    check("t5_irq", {31'd0, irq_a}, 32'd0);
    check("t5_rd", rd_a, 32'd0);
    check("t5_state", {30'd0, st_a}, 32'd0);
    ticks(2);
    rst_n = 1'b1;
    clear_mon();
    tick();
    bus_read(0, 2'd1, r);
    check("t5_status", r, 32'h0011);
    ticks(20);
    check("t5_no_pulse", pulse_a.size(), 32'd0);

    // 6) same-cycle write and read.
    clear_mon();
    c0 = cyc;
    bus_wr_rd(2'd0, 32'hC3, r);
    check("t6_data_read", r, 32'd0);
    wait_pulses(0, 1, 10, "t6_pulse");
    if (pulse_a.size() == 1) begin
      check("t6_byte", {24'd0, pulse_a[0]}, 32'hC3);
      check("t6_latency", pcyc_a[0] - c0, 32'd2);
    end
    ticks(8);
    bus_wr_rd(2'd2, 32'h0, r);
    check("t6_ctrl_prewrite", r, 32'h2);
    bus_read(0, 2'd2, r);
    check("t6_ctrl_after", r, 32'h0);
    bus_write(0, 2'd2, 32'h2);
    bus_wr_rd(2'd3, 32'hFFFF_FFFF, r);
    check("t6_reserved", r, 32'd0);
    bus_read(0, 2'd1, r);
    check("t6_status", r, 32'h0011);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
